// File: rtl/apb_pkg.sv
// Shared types and constants for the APB initiator.
package apb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

    localparam int APB_WIN_BITS = 12;

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps the upper address bits onto one of NUM_SLAVES 4 KB APB windows.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic [31:APB_WIN_BITS] addr_i,
    output logic                   hit_o,
    output logic [3:0]             idx_o
);

    localparam logic [4:0] NS = 5'(NUM_SLAVES);

    assign idx_o = addr_i[APB_WIN_BITS+3:APB_WIN_BITS];
    assign hit_o = (addr_i[31:16] == BASE_ADDR[31:16]) && ({1'b0, idx_o} < NS);

endmodule

// File: rtl/apb_master.sv
// APB initiator: one CPU request at a time, decoded onto a PSEL window,
// SETUP/ACCESS sequencing with a bounded wait and a one-cycle response.
module apb_master
    import apb_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          TIMEOUT    = 16
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [31:0]                 req_addr,
    input  logic [31:0]                 req_wdata,
    input  logic                        req_write,
    output logic                        rsp_valid,
    output logic [31:0]                 rsp_rdata,
    output logic                        rsp_err,
    output logic [31:0]                 PADDR,
    output logic [31:0]                 PWDATA,
    output logic                        PWRITE,
    output logic [NUM_SLAVES-1:0]       PSEL,
    output logic                        PENABLE,
    input  logic [NUM_SLAVES-1:0][31:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]       PREADY
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    apb_state_e            state_q;
    logic [CW-1:0]         cnt_q;
    logic [31:0]           paddr_q, pwdata_q, rsp_rdata_q;
    logic                  pwrite_q, penable_q, rsp_valid_q, rsp_err_q;
    logic [NUM_SLAVES-1:0] psel_q;

    logic [31:APB_WIN_BITS] dec_addr;
    logic                   dec_hit;
    logic [3:0]             dec_idx;
    logic [NUM_SLAVES-1:0]  sel_onehot;
    logic                   sel_ready;
    logic [31:0]            sel_rdata;

    // Decode the live request while idle, the held PADDR during a transfer,
    // so one decoder serves both the PSEL choice and the PREADY/PRDATA mux.
    assign dec_addr = (state_q == IDLE) ? req_addr[31:APB_WIN_BITS]
                                        : paddr_q[31:APB_WIN_BITS];

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .BASE_ADDR  (BASE_ADDR)
    ) u_dec (
        .addr_i (dec_addr),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx)
    );

    always_comb begin
        sel_onehot = '0;
        sel_ready  = 1'b0;
        sel_rdata  = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (dec_idx == 4'(s)) begin
                sel_onehot[s] = 1'b1;
                sel_ready     = PREADY[s];
                sel_rdata     = PRDATA[s];
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        paddr_q  <= req_addr;
                        pwdata_q <= req_wdata;
                        pwrite_q <= req_write;
                        if (dec_hit) begin
                            state_q <= SETUP;
                            psel_q  <= sel_onehot;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                end
                ACCESS: begin
                    // A ready on the final allowed cycle still completes normally.
                    if (sel_ready) begin
                        state_q     <= IDLE;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pwrite_q ? 32'h0 : sel_rdata;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q     <= IDLE;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    psel_q    <= '0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed plus randomized transfers against a transaction-level model of the APB initiator.
module tb_apb_master;

    localparam int NS = 4;
    localparam int TO = 16;

    logic                PCLK = 1'b0;
    logic                PRESET;
    logic                req_valid, req_ready, req_write;
    logic [31:0]         req_addr, req_wdata;
    logic                rsp_valid, rsp_err;
    logic [31:0]         rsp_rdata;
    logic [31:0]         PADDR, PWDATA;
    logic                PWRITE, PENABLE;
    logic [NS-1:0]       PSEL;
    logic [NS-1:0][31:0] PRDATA;
    logic [NS-1:0]       PREADY;

    int n_checks = 0;
    int n_pass   = 0;

    apb_master #(.NUM_SLAVES(NS), .BASE_ADDR(32'h1000_0000), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_write(req_write),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Called at posedge+1 with the DUT idle. The slave on the decoded window
    // raises PREADY on ACCESS cycle number waitc (0-based); other lines carry noise.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic wr, input int waitc, input bit gap);
        bit          hit, got, bus_ok, exp_err;
        int          idx, nacc, exp_lat, lat, psel_n, pen_n, acc;
        logic [31:0] rdval, exp_rd, r_data;
        logic        r_err;
        idx   = int'(addr[15:12]);
        hit   = (addr[31:16] == 16'h1000) && (idx < NS);
        rdval = $urandom;
        if (hit) PRDATA[idx] = rdval;
        nacc    = hit ? ((waitc + 1 < TO) ? waitc + 1 : TO) : 0;
        exp_lat = hit ? nacc + 2 : 1;
        exp_err = !hit || (waitc >= TO);
        exp_rd  = (exp_err || wr) ? 32'h0 : rdval;

        chk("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_write = wr;
        got = 0; bus_ok = 1; lat = 0; psel_n = 0; pen_n = 0; acc = 0;
        r_data = '0; r_err = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(posedge PCLK); #1;
            req_valid = 1'b0;
            for (int s = 0; s < NS; s++)
                if (!hit || s != idx) PRDATA[s] = $urandom;
            if (rsp_valid) begin
                got = 1; lat = c; r_data = rsp_rdata; r_err = rsp_err;
            end
            psel_n += (PSEL != '0) ? 1 : 0;
            pen_n  += PENABLE ? 1 : 0;
            if (PSEL != '0) begin
                if (!hit || PSEL != NS'(1 << idx) || PADDR !== addr ||
                    PWRITE !== wr || PWDATA !== wdata) bus_ok = 0;
            end
            if (PENABLE && PSEL == '0) bus_ok = 0;
            if (!got) begin
                PREADY = NS'($urandom);
                if (hit && PENABLE) begin
                    PREADY[idx] = (acc == waitc);
                    acc++;
                end
            end
        end
        chk("rsp_seen",    32'(got), 1);
        chk("rsp_latency", 32'(lat), 32'(exp_lat));
        chk("rsp_err",     32'(r_err), 32'(exp_err));
        chk("rsp_rdata",   r_data, exp_rd);
        chk("psel_cycles", 32'(psel_n), hit ? 32'(1 + nacc) : 32'h0);
        chk("penable_cycles", 32'(pen_n), 32'(nacc));
        chk("bus_protocol", 32'(bus_ok), 1);
        if (gap) begin
            @(posedge PCLK); #1;
            chk("rsp_one_cycle", 32'(rsp_valid), 0);
            chk("ready_after",   32'(req_ready), 1);
        end
    endtask

    initial begin
        logic [31:0] a;
        int          w;
        PRESET = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_write = 1'b0;
        PREADY = '0; PRDATA = '0;
        #3;
        chk("rst_psel",    32'(PSEL), 0);
        chk("rst_penable", 32'(PENABLE), 0);
        chk("rst_rsp",     {rsp_valid, rsp_err, 30'h0}, 0);
        chk("rst_rdata",   rsp_rdata, 0);
        chk("rst_paddr",   PADDR, 0);
        chk("rst_pwdata",  PWDATA, 0);
        chk("rst_pwrite",  32'(PWRITE), 0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        // Directed cases
        run_txn(32'h1000_0008, 32'h0000_00AA, 1'b1, 1, 1'b1);
        run_txn(32'h1000_1004, 32'h0,         1'b0, 3, 1'b1);
        run_txn(32'h2000_0000, 32'h0,         1'b0, 0, 1'b1);
        run_txn(32'h1000_4000, 32'h0,         1'b0, 0, 1'b1);
        run_txn(32'h1000_2010, 32'h0,         1'b0, 99, 1'b1);
        run_txn(32'h1000_2014, 32'h0,         1'b0, TO - 1, 1'b1);
        run_txn(32'h1000_2018, 32'h0,         1'b0, TO, 1'b1);
        run_txn(32'h1000_0000, 32'h1234_5678, 1'b1, 0, 1'b0);
        run_txn(32'h1000_3000, 32'h0,         1'b0, 2, 1'b1);

        // Reset in the middle of an ACCESS phase
        req_valid = 1'b1; req_addr = 32'h1000_1000; req_wdata = 32'hDEAD_BEEF; req_write = 1'b1;
        PREADY = '0;
        @(posedge PCLK); #1; req_valid = 1'b0;
        @(posedge PCLK); #1;
        chk("pre_rst_penable", 32'(PENABLE), 1);
        #2 PRESET = 1'b1;
        #1;
        chk("async_psel",    32'(PSEL), 0);
        chk("async_penable", 32'(PENABLE), 0);
        @(posedge PCLK); #1;
        chk("rst_no_rsp", 32'(rsp_valid), 0);
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        chk("post_rst_rsp",   32'(rsp_valid), 0);
        chk("post_rst_ready", 32'(req_ready), 1);
        run_txn(32'h1000_0020, 32'h0BAD_F00D, 1'b1, 1, 1'b1);

        // Randomized traffic: mostly hits, some misses, some long waits
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 5))
                0:       a = {16'h1000, 4'($urandom_range(NS, 15)), 12'($urandom)};
                1:       a = {16'($urandom_range(0, 16'hFFFF)) | 16'h2000, 16'($urandom)};
                default: a = {16'h1000, 4'($urandom_range(0, NS - 1)), 12'($urandom)};
            endcase
            w = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 5);
            run_txn(a, $urandom, 1'($urandom), w, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
